// File: rtl/vga_timing_pkg.sv
// Shared timing constants and sizing helpers for the VGA raster generator.
// The defaults describe standard 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  // Full period of one axis: active area plus all blanking segments.
  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Minimum counter width able to hold total-1.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel clock-enable divider: pix_tick is high for one clk out of every CLK_DIV.
// With CLK_DIV=1 the count never leaves 0, so the tick is permanently high.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pix_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with colour gating, line/frame
// strobes and a completed-frame counter. All outputs except pix_tick are registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int CNT_W    = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] iRED,
  input  logic [COLOR_W-1:0] iGREEN,
  input  logic [COLOR_W-1:0] iBLUE,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic [CNT_W-1:0]   x_cor,
  output logic [CNT_W-1:0]   y_cor,
  output logic               video_on,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic [FRAME_W-1:0] frame_q;
  logic               h_wrapped;
  logic               f_wrapped;

  logic h_end;
  logic v_end;
  logic hs_window;
  logic vs_window;
  logic active;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick)
  );

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  // Raster state. The wrap flags sit alongside the counters so the strobes
  // fire only on a real transition to 0, never on the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_q   <= '0;
      h_wrapped <= 1'b0;
      f_wrapped <= 1'b0;
    end else begin
      h_wrapped <= pix_tick && h_end;
      f_wrapped <= pix_tick && h_end && v_end;
      if (pix_tick) begin
        h_cnt <= h_end ? '0 : h_cnt + 1'b1;
        if (h_end) begin
          v_cnt <= v_end ? '0 : v_cnt + 1'b1;
          if (v_end) begin
            frame_q <= frame_q + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: pure continuous decode with no conditional paths, so no latch can form.
  assign hs_window = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_window = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // Output stage: one clk behind the counters; colour is sampled in the same clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_HSYNC   <= ~HS_POL;
      VGA_VSYNC   <= ~VS_POL;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      x_cor       <= '0;
      y_cor       <= '0;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      VGA_HSYNC   <= hs_window ? HS_POL : ~HS_POL;
      VGA_VSYNC   <= vs_window ? VS_POL : ~VS_POL;
      VGA_R       <= active ? iRED   : '0;
      VGA_G       <= active ? iGREEN : '0;
      VGA_B       <= active ? iBLUE  : '0;
      x_cor       <= h_cnt;
      y_cor       <= v_cnt;
      video_on    <= active;
      line_start  <= h_wrapped;
      frame_start <= f_wrapped;
      frame_cnt   <= frame_q;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four generator configurations run side by side against
// an arithmetic model of the raster derived from the elapsed clock count.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ired = '0, igreen = '0, iblue = '0;
  logic [3:0] r_q = '0, g_q = '0, b_q = '0;
  int         n = 0;
  int         tot = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       tick;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb, d;
    bit hp, vp;
  } cfg_t;

  cfg_t c0, c1, c2, c3;

  logic       hs0, vs0, von0, tk0, ls0, fs0; logic [3:0] r0, g0, b0; logic [9:0] x0, y0; logic [7:0] fc0;
  logic       hs1, vs1, von1, tk1, ls1, fs1; logic [3:0] r1, g1, b1; logic [9:0] x1, y1; logic [7:0] fc1;
  logic       hs2, vs2, von2, tk2, ls2, fs2; logic [3:0] r2, g2, b2; logic [9:0] x2, y2; logic [7:0] fc2;
  logic       hs3, vs3, von3, tk3, ls3, fs3; logic [3:0] r3, g3, b3; logic [9:0] x3, y3; logic [7:0] fc3;
  obs_t act0, act1, act2, act3;

  assign act0 = {hs0, vs0, r0, g0, b0, x0, y0, von0, tk0, ls0, fs0, fc0};
  assign act1 = {hs1, vs1, r1, g1, b1, x1, y1, von1, tk1, ls1, fs1, fc1};
  assign act2 = {hs2, vs2, r2, g2, b2, x2, y2, von2, tk2, ls2, fs2, fc2};
  assign act3 = {hs3, vs3, r3, g3, b3, x3, y3, von3, tk3, ls3, fs3, fc3};

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0)) d0 (
    .clk(clk), .reset(reset), .iRED(ired), .iGREEN(igreen), .iBLUE(iblue),
    .VGA_HSYNC(hs0), .VGA_VSYNC(vs0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
    .x_cor(x0), .y_cor(y0), .video_on(von0), .pix_tick(tk0),
    .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b0)) d1 (
    .clk(clk), .reset(reset), .iRED(ired), .iGREEN(igreen), .iBLUE(iblue),
    .VGA_HSYNC(hs1), .VGA_VSYNC(vs1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .x_cor(x1), .y_cor(y1), .video_on(von1), .pix_tick(tk1),
    .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1)) d2 (
    .clk(clk), .reset(reset), .iRED(ired), .iGREEN(igreen), .iBLUE(iblue),
    .VGA_HSYNC(hs2), .VGA_VSYNC(vs2), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
    .x_cor(x2), .y_cor(y2), .video_on(von2), .pix_tick(tk2),
    .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2));

  vga_timing_gen #(.CLK_DIV(2)) d3 (
    .clk(clk), .reset(reset), .iRED(ired), .iGREEN(igreen), .iBLUE(iblue),
    .VGA_HSYNC(hs3), .VGA_VSYNC(vs3), .VGA_R(r3), .VGA_G(g3), .VGA_B(b3),
    .x_cor(x3), .y_cor(y3), .video_on(von3), .pix_tick(tk3),
    .line_start(ls3), .frame_start(fs3), .frame_cnt(fc3));

  // Reference: after n non-reset edges, p = n/d pixels have elapsed; registered
  // outputs show the raster position one clk earlier.
  function automatic obs_t model(input cfg_t c, input int cyc,
                                 input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    obs_t e;
    int ht, vt, m, p, h, v;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    e = '0;
    e.hs = ~c.hp;
    e.vs = ~c.vp;
    e.tick = ((cyc % c.d) == c.d - 1);
    if (cyc == 0) return e;
    m = cyc - 1;
    p = m / c.d;
    h = p % ht;
    v = (p / ht) % vt;
    e.x = 10'(h);
    e.y = 10'(v);
    e.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
    e.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
    e.von = (h < c.ha) && (v < c.va);
    if (e.von) begin
      e.r = r;
      e.g = g;
      e.b = b;
    end
    e.ls = (m >= 1) && (p != (m - 1) / c.d) && (h == 0);
    e.fs = e.ls && (v == 0);
    e.fc = 8'((p / (ht * vt)) % 256);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) n = 0;
    else n++;
    r_q = ired;
    g_q = igreen;
    b_q = iblue;
    @(negedge clk);
  endtask

  task automatic rand_colour();
    ired   = 4'($urandom);
    igreen = 4'($urandom);
    iblue  = 4'($urandom);
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b1;
    rand_colour();
    step();
    step();
    e = model(c0, n, r_q, g_q, b_q);
    tot++; if (act0 !== e) begin bad++; $display("FAIL reset_d0 got=%p want=%p", act0, e); end
    e = model(c1, n, r_q, g_q, b_q);
    tot++; if (act1 !== e) begin bad++; $display("FAIL reset_d1 got=%p want=%p", act1, e); end
    e = model(c2, n, r_q, g_q, b_q);
    tot++; if (act2 !== e) begin bad++; $display("FAIL reset_d2 got=%p want=%p", act2, e); end
    e = model(c3, n, r_q, g_q, b_q);
    tot++; if (act3 !== e) begin bad++; $display("FAIL reset_d3 got=%p want=%p", act3, e); end
    tot++;
    if (hs2 !== 1'b0 || vs2 !== 1'b0 || hs0 !== 1'b1 || vs0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_sync_levels got=%b%b%b%b want=1100", hs0, vs0, hs2, vs2);
    end
    reset = 1'b0;
  endtask

  task automatic test_small_raster();
    obs_t e;
    int   last_fs = -1;
    for (int i = 0; i < 400; i++) begin
      rand_colour();
      step();
      e = model(c0, n, r_q, g_q, b_q);
      tot++;
      if (act0 !== e) begin
        bad++;
        if (bad < 20) $display("FAIL small_raster n=%0d got=%p want=%p", n, act0, e);
      end
      if (fs0 === 1'b1) begin
        if (last_fs >= 0) begin
          tot++;
          if (n - last_fs != 98) begin
            bad++;
            $display("FAIL frame_period got=%0d want=98", n - last_fs);
          end
        end
        last_fs = n;
      end
    end
  endtask

  task automatic test_clk_div();
    obs_t e;
    int   ticks = 0;
    for (int i = 0; i < 300; i++) begin
      rand_colour();
      step();
      if (tk1 === 1'b1) ticks++;
      e = model(c1, n, r_q, g_q, b_q);
      tot++;
      if (act1 !== e) begin
        bad++;
        if (bad < 20) $display("FAIL clk_div n=%0d got=%p want=%p", n, act1, e);
      end
    end
    tot++;
    if (ticks != 100) begin bad++; $display("FAIL tick_rate got=%0d want=100", ticks); end
  endtask

  task automatic test_colour();
    obs_t e;
    ired = 4'hF; igreen = 4'h0; iblue = 4'hA;
    for (int i = 0; i < 200; i++) begin
      step();
      e = model(c0, n, r_q, g_q, b_q);
      tot++;
      if (act0 !== e) begin
        bad++;
        if (bad < 20) $display("FAIL colour n=%0d got=%p want=%p", n, act0, e);
      end
      tot++;
      if (x0 >= 10'd8 || y0 >= 10'd4) begin
        if ({r0, g0, b0} !== 12'h000) begin
          bad++; $display("FAIL colour_blank x=%0d y=%0d got=%h want=000", x0, y0, {r0, g0, b0});
        end
      end else if ({r0, g0, b0} !== 12'hF0A) begin
        bad++; $display("FAIL colour_active x=%0d y=%0d got=%h want=f0a", x0, y0, {r0, g0, b0});
      end
    end
  endtask

  task automatic test_polarity();
    obs_t e;
    for (int i = 0; i < 300; i++) begin
      rand_colour();
      step();
      e = model(c2, n, r_q, g_q, b_q);
      tot++;
      if (act2 !== e) begin
        bad++;
        if (bad < 20) $display("FAIL polarity n=%0d got=%p want=%p", n, act2, e);
      end
      tot++;
      if (hs2 !== (x2 == 10'd10 || x2 == 10'd11) || vs2 !== (y2 == 10'd5)) begin
        bad++; $display("FAIL polarity_window x=%0d y=%0d got=%b%b", x2, y2, hs2, vs2);
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    bit   found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      rand_colour();
      step();
      found = (x0 == 10'd5 && y0 == 10'd3);
    end
    tot++;
    if (!found) begin bad++; $display("FAIL mid_reset_reach got=%0d,%0d want=5,3", x0, y0); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    tot++;
    if (x0 !== 10'd0 || y0 !== 10'd0 || hs0 !== 1'b1 || vs0 !== 1'b1 || fc0 !== 8'd0 || fs0 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_restart got x=%0d y=%0d hs=%b vs=%b fc=%0d fs=%b want 0 0 1 1 0 0",
               x0, y0, hs0, vs0, fc0, fs0);
    end
    for (int i = 0; i < 120; i++) begin
      rand_colour();
      step();
      e = model(c0, n, r_q, g_q, b_q);
      tot++; if (act0 !== e) begin bad++; if (bad < 20) $display("FAIL mid_reset_d0 n=%0d got=%p want=%p", n, act0, e); end
      e = model(c1, n, r_q, g_q, b_q);
      tot++; if (act1 !== e) begin bad++; if (bad < 20) $display("FAIL mid_reset_d1 n=%0d got=%p want=%p", n, act1, e); end
      e = model(c2, n, r_q, g_q, b_q);
      tot++; if (act2 !== e) begin bad++; if (bad < 20) $display("FAIL mid_reset_d2 n=%0d got=%p want=%p", n, act2, e); end
      e = model(c3, n, r_q, g_q, b_q);
      tot++; if (act3 !== e) begin bad++; if (bad < 20) $display("FAIL mid_reset_d3 n=%0d got=%p want=%p", n, act3, e); end
    end
  endtask

  task automatic test_default_hsync();
    obs_t e;
    logic prev_hs = 1'b1;
    int   last_fall = -1;
    int   falls = 0;
    for (int i = 0; i < 5000; i++) begin
      rand_colour();
      step();
      e = model(c3, n, r_q, g_q, b_q);
      tot++;
      if (act3 !== e) begin
        bad++;
        if (bad < 20) $display("FAIL default n=%0d got=%p want=%p", n, act3, e);
      end
      if (prev_hs === 1'b1 && hs3 === 1'b0) begin
        if (last_fall >= 0) begin
          tot++;
          if (n - last_fall != 1600) begin bad++; $display("FAIL hsync_period got=%0d want=1600", n - last_fall); end
        end
        last_fall = n;
        falls++;
      end
      if (prev_hs === 1'b0 && hs3 === 1'b1 && last_fall >= 0) begin
        tot++;
        if (n - last_fall != 192) begin bad++; $display("FAIL hsync_width got=%0d want=192", n - last_fall); end
      end
      prev_hs = hs3;
    end
    tot++;
    if (falls < 2) begin bad++; $display("FAIL hsync_seen got=%0d want>=2", falls); end
  endtask

  task automatic test_frame_wrap();
    obs_t e;
    logic [7:0] prev_fc = fc0;
    bit         seen = 1'b0;
    for (int i = 0; i < 30000 && !seen; i++) begin
      rand_colour();
      step();
      e = model(c0, n, r_q, g_q, b_q);
      tot++;
      if (act0 !== e) begin
        bad++;
        if (bad < 20) $display("FAIL frame_wrap n=%0d got=%p want=%p", n, act0, e);
      end
      if (prev_fc == 8'd255 && fc0 == 8'd0) seen = 1'b1;
      prev_fc = fc0;
    end
    tot++;
    if (!seen) begin bad++; $display("FAIL frame_cnt_wrap got=%0d want wrap 255->0", fc0); end
  endtask

  initial begin
    c0 = '{ha: 8, hf: 2, hsw: 2, hb: 2, va: 4, vf: 1, vsw: 1, vb: 1, d: 1, hp: 1'b0, vp: 1'b0};
    c1 = '{ha: 8, hf: 2, hsw: 2, hb: 2, va: 4, vf: 1, vsw: 1, vb: 1, d: 3, hp: 1'b0, vp: 1'b0};
    c2 = '{ha: 8, hf: 2, hsw: 2, hb: 2, va: 4, vf: 1, vsw: 1, vb: 1, d: 1, hp: 1'b1, vp: 1'b1};
    c3 = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33, d: 2, hp: 1'b0, vp: 1'b0};
    @(negedge clk);
    test_reset();
    test_small_raster();
    test_clk_div();
    test_colour();
    test_polarity();
    test_mid_reset();
    test_default_hsync();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
